id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

ID/EX pipeline register of the five-stage RISC-V core, directly upstream of the ALU control unit and ALU. Each cycle it captures the decoded instruction word, operands, immediate and main-decoder control bits, and presents them to EX. The instruction word drives the ALU control decode on bits [31:25] and [14:12], and `ex_alu_op` supplies its 2-bit ALUOp. The block also detects load-use hazards, inserts bubbles, and honours flush and hold requests from the rest of the pipeline.

## Interface
Parameters:
- `XLEN`, 32, datapath width for PC, operands and immediate.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID slot holds a real instruction.
- `id_instr`  in  32  instruction word from IF/ID.
- `id_pc`  in  XLEN  PC of the ID instruction.
- `id_rs1_data`, `id_rs2_data`  in  XLEN  register-file read data.
- `id_imm`  in  XLEN  sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  5  register indices.
- `id_alu_op`  in  2  ALUOp from the main decoder.
- `id_alu_src`, `id_mem_read`, `id_mem_write`, `id_reg_write`, `id_mem_to_reg`, `id_branch`  in  1  main-decoder controls.
- `ex_flush`  in  1  squash the instruction entering EX (branch taken or redirect).
- `ex_hold`  in  1  freeze the EX register (downstream memory stall).
- `ex_*`  out  matches the corresponding `id_*` input  registered copies of every `id_*` input above, plus `ex_valid`.
- `stall_out`  out  1  load-use stall request to PC and IF/ID (hold both).

## Operation
- Update priority at each rising edge: `rst` > `ex_flush` > `ex_hold` > load-use bubble > normal load.
- **Normal load:** every `ex_*` register takes its `id_*` value, and `ex_valid` takes `id_valid`.
- **Hold:** all `ex_*` registers keep their values.
- **Bubble and flush:** these produce the same state:
  - `ex_valid`=0.
  - `ex_instr`=32'h0000_0013 (NOP, addi x0,x0,0).
  - `ex_alu_op`=2'b00.
  - All six 1-bit controls = 0.
  - `ex_rd`/`ex_rs1`/`ex_rs2` = 0.
  - PC, data and immediate registers = 0.
- **Load-use hazard (combinational):** asserted when all of the following hold:
  - `ex_valid` & `ex_mem_read` & `id_valid`;
  - `ex_rd`≠0;
  - `ex_rd`==`id_rs1`, or (`ex_rd`==`id_rs2` & `id_alu_src`==0 or `id_mem_write`==1).
- `stall_out` = hazard & ~`ex_flush`. A flush wins because the ID instruction is being squashed anyway.
- **Hazard during `ex_hold`:** `stall_out` stays asserted. The EX contents are held, not bubbled. The bubble is inserted on the first edge with `ex_hold`=0.
- At most one bubble per load. After the bubble, `ex_mem_read`=0, so the stalled instruction loads on the next edge.
- Register indices are compared full 5-bit. x0 never creates a hazard.

## Timing
- Latency: `id_*` to `ex_*` is one cycle. `stall_out` is combinational from the `ex_*` registers and `id_*` inputs, with no registered delay.
- Reset (asynchronous, takes effect immediately): all outputs go to the bubble/flush state.
- Reset asserted mid-stall: `stall_out` drops to 0 immediately, because `ex_valid`=0.
- Release of `rst` is synchronised externally. The first edge after release performs a normal load.
- `ex_flush` and `ex_hold` both high: flush wins and a bubble is written.
- No combinational path from `ex_flush` or `ex_hold` to any `ex_*` output.

## Configuration
- `LOAD_USE_DETECT_EN` defined: hazard detection, `stall_out` and automatic bubble insertion behave as described above.
- `LOAD_USE_DETECT_EN` undefined:
  - `stall_out` is tied to 0 and the hazard logic is not synthesised.
  - Priority reduces to `rst` > `ex_flush` > `ex_hold` > normal load.
  - Software or the compiler must schedule around load-use hazards.

## Test plan
- **Reset mid-operation:** load a valid instruction (`ex_valid`=1, `ex_instr`=0x0062_82B3), then assert `rst` between edges → immediately `ex_valid`=0, `ex_instr`=0x0000_0013, `ex_alu_op`=00, all controls 0.
- **Load-use stall:** EX holds lw with `ex_rd`=5 and `ex_mem_read`=1; ID holds add x7,x5,x6 (`id_rs1`=5) → `stall_out`=1 that cycle. Next edge: bubble (`ex_valid`=0, `ex_instr`=0x13) and `stall_out`=0. Following edge: `ex_instr` = the add and `ex_alu_op`=10.
- **No false hazards:**
  - lw with `ex_rd`=0 and ID `id_rs1`=0 → `stall_out`=0, normal load.
  - lw `ex_rd`=5 and ID addi using `id_rs2`=5 with `id_alu_src`=1 → `stall_out`=0.
- **Flush over hazard:** hazard present and `ex_flush`=1 → `stall_out`=0. Next edge: bubble state, even with `id_valid`=1.
- **Hold:** `ex_hold`=1 for 3 cycles while the `id_*` inputs change each cycle → `ex_*` unchanged for all 3 cycles. Hold plus hazard → `stall_out` stays 1 throughout, and the bubble appears on the first edge after `ex_hold` falls.
- **`LOAD_USE_DETECT_EN` undefined:** repeat the load-use stimulus → `stall_out`=0, and the add loads directly on the next edge with no bubble.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use bubble, flush and hold.
// Optional hazard detection and bubble insertion are enabled by LOAD_USE_DETECT_EN.
module id_ex_pipe_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [31:0]     id_instr,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  input  logic            ex_flush,
  input  logic            ex_hold,
  output logic            ex_valid,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [1:0]      ex_alu_op,
  output logic            ex_alu_src,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic            stall_out
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [1:0]      r_alu_op;
  logic            r_alu_src;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_reg_write;
  logic            r_mem_to_reg;
  logic            r_branch;

  logic            w_hazard;
  logic            w_clear;
  logic            w_load;

`ifdef LOAD_USE_DETECT_EN
  logic w_rs1_match;
  logic w_rs2_match;

  // rs2 only matters when it is actually read: R-type/branch (alu_src=0) or store data.
  assign w_rs1_match = (r_rd == id_rs1);
  assign w_rs2_match = (r_rd == id_rs2) && (!id_alu_src || id_mem_write);
  assign w_hazard    = r_valid && r_mem_read && id_valid && (r_rd != 5'd0) &&
                       (w_rs1_match || w_rs2_match);
`else
  assign w_hazard    = 1'b0;
`endif

  assign stall_out = w_hazard && !ex_flush;
  assign w_clear   = ex_flush || (!ex_hold && w_hazard);
  assign w_load    = !ex_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_clear) begin
      r_valid      <= 1'b0;
      r_instr      <= NOP;
      r_pc         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_rd         <= 5'd0;
      r_alu_op     <= 2'b00;
      r_alu_src    <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_branch     <= 1'b0;
    end else if (w_load) begin
      r_valid      <= id_valid;
      r_instr      <= id_instr;
      r_pc         <= id_pc;
      r_rs1_data   <= id_rs1_data;
      r_rs2_data   <= id_rs2_data;
      r_imm        <= id_imm;
      r_rs1        <= id_rs1;
      r_rs2        <= id_rs2;
      r_rd         <= id_rd;
      r_alu_op     <= id_alu_op;
      r_alu_src    <= id_alu_src;
      r_mem_read   <= id_mem_read;
      r_mem_write  <= id_mem_write;
      r_reg_write  <= id_reg_write;
      r_mem_to_reg <= id_mem_to_reg;
      r_branch     <= id_branch;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_instr      = r_instr;
  assign ex_pc         = r_pc;
  assign ex_rs1_data   = r_rs1_data;
  assign ex_rs2_data   = r_rs2_data;
  assign ex_imm        = r_imm;
  assign ex_rs1        = r_rs1;
  assign ex_rs2        = r_rs2;
  assign ex_rd         = r_rd;
  assign ex_alu_op     = r_alu_op;
  assign ex_alu_src    = r_alu_src;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_to_reg = r_mem_to_reg;
  assign ex_branch     = r_branch;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed self-checking bench for id_ex_pipe_reg.
module tb_id_ex_pipe_reg;

  logic        clk, rst;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch;
  logic        ex_flush, ex_hold;
  logic        ex_valid;
  logic [31:0] ex_instr, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [1:0]  ex_alu_op;
  logic        ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch;
  logic        stall_out;

  int n_checks = 0;
  int n_errors = 0;

`ifdef LOAD_USE_DETECT_EN
  localparam logic DET = 1'b1;
`else
  localparam logic DET = 1'b0;
`endif

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADD_5    = 32'h0062_82B3;
  localparam logic [31:0] LW_X5    = 32'h0005_2283;
  localparam logic [31:0] LW_X0    = 32'h0005_2003;
  localparam logic [31:0] ADD_X7   = 32'h0062_83B3;
  localparam logic [31:0] ADD_X7_0 = 32'h0060_03B3;
  localparam logic [31:0] ADDI_X7  = 32'h0053_0393;

  id_ex_pipe_reg #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_branch(id_branch),
    .ex_flush(ex_flush), .ex_hold(ex_hold),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .stall_out(stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives ID inputs; data/pc/imm derive from the instruction so loads are traceable.
  task automatic set_id(input logic v, input logic [31:0] ins, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic [1:0] op,
                        input logic src, input logic mr, input logic mw, input logic rw,
                        input logic m2r);
    id_valid = v; id_instr = ins; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_alu_op = op; id_alu_src = src; id_mem_read = mr; id_mem_write = mw;
    id_reg_write = rw; id_mem_to_reg = m2r; id_branch = 1'b0;
    id_pc = ins ^ 32'h0000_1000; id_rs1_data = ~ins; id_rs2_data = ins + 32'd7;
    id_imm = {ins[31:20], 20'h0};
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, "_instr"}, ex_instr, NOP);
    chk({tag, "_aluop"}, {30'd0, ex_alu_op}, 32'd0);
    chk({tag, "_ctrl"}, {26'd0, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
                         ex_mem_to_reg, ex_branch}, 32'd0);
    chk({tag, "_rd"}, {27'd0, ex_rd}, 32'd0);
    chk({tag, "_pc"}, ex_pc, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ex_flush = 1'b0; ex_hold = 1'b0;
    set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #12;
    chk_bubble("reset");
    chk("reset_stall", {31'd0, stall_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Normal load of add x5,x5,x6
    set_id(1'b1, ADD_5, 5'd5, 5'd6, 5'd5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("load_valid", {31'd0, ex_valid}, 32'd1);
    chk("load_instr", ex_instr, ADD_5);
    chk("load_pc", ex_pc, 32'h0062_92B3);
    chk("load_rs1d", ex_rs1_data, 32'hFF9D_7D4C);
    chk("load_rs2d", ex_rs2_data, 32'h0062_82BA);
    chk("load_imm", ex_imm, 32'h0060_0000);
    chk("load_regs", {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, 5'd5, 5'd6, 5'd5});
    chk("load_aluop", {30'd0, ex_alu_op}, 32'd2);
    chk("load_rw", {31'd0, ex_reg_write}, 32'd1);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1 chk_bubble("arst");
    @(negedge clk);
    rst = 1'b0;

    // Load-use: lw x5 in EX, add x7,x5,x6 in ID
    set_id(1'b1, LW_X5, 5'd10, 5'd0, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk("lw_memrd", {31'd0, ex_mem_read}, 32'd1);
    set_id(1'b1, ADD_X7, 5'd5, 5'd6, 5'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("lu_stall", {31'd0, stall_out}, {31'd0, DET});
    tick();
`ifdef LOAD_USE_DETECT_EN
    chk_bubble("lu_bubble");
    chk("lu_stall_after", {31'd0, stall_out}, 32'd0);
    tick();
`endif
    chk("lu_add_instr", ex_instr, ADD_X7);
    chk("lu_add_aluop", {30'd0, ex_alu_op}, 32'd2);
    chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);

    // lw x0 followed by a reader of x0: no hazard
    set_id(1'b1, LW_X0, 5'd10, 5'd0, 5'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, ADD_X7_0, 5'd0, 5'd6, 5'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("x0_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("x0_instr", ex_instr, ADD_X7_0);

    // lw x5 then addi whose rs2 field is 5 but uses the immediate
    set_id(1'b1, LW_X5, 5'd10, 5'd0, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, ADDI_X7, 5'd6, 5'd5, 5'd7, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("imm_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk("imm_instr", ex_instr, ADDI_X7);

    // Flush overrides hazard
    set_id(1'b1, LW_X5, 5'd10, 5'd0, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, ADD_X7, 5'd5, 5'd6, 5'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ex_flush = 1'b1; ex_hold = 1'b1;
    #1 chk("flush_stall", {31'd0, stall_out}, 32'd0);
    tick();
    chk_bubble("flush");
    ex_flush = 1'b0; ex_hold = 1'b0;

    // Hold for 3 cycles with changing ID inputs
    set_id(1'b1, ADD_5, 5'd5, 5'd6, 5'd5, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b0, 32'h1000_0000 + i, 5'd1, 5'd2, 5'd3, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk("hold_instr", ex_instr, ADD_5);
      chk("hold_pc", ex_pc, 32'h0062_92B3);
      chk("hold_valid", {31'd0, ex_valid}, 32'd1);
    end
    ex_hold = 1'b0;

    // Hold with a pending load-use hazard
    set_id(1'b1, LW_X5, 5'd10, 5'd0, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, ADD_X7, 5'd5, 5'd6, 5'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hh_stall", {31'd0, stall_out}, {31'd0, DET});
      tick();
      chk("hh_instr", ex_instr, LW_X5);
    end
    ex_hold = 1'b0;
    #1 chk("hh_stall_rel", {31'd0, stall_out}, {31'd0, DET});
    tick();
`ifdef LOAD_USE_DETECT_EN
    chk_bubble("hh_bubble");
    tick();
`endif
    chk("hh_add", ex_instr, ADD_X7);

    // Reset asserted while a stall is pending
    set_id(1'b1, LW_X5, 5'd10, 5'd0, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    set_id(1'b1, ADD_X7, 5'd5, 5'd6, 5'd7, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 chk("rs_stall_pre", {31'd0, stall_out}, {31'd0, DET});
    rst = 1'b1;
    #1 chk("rs_stall_post", {31'd0, stall_out}, 32'd0);
    chk("rs_valid", {31'd0, ex_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rs_first_load", ex_instr, ADD_X7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
